// File: rtl/multimode_counter_core.sv
// Purpose : WIDTH-bit up/down counter (step 1 or 2) that tallies all-ones (win) and
//           zero (lose) landings and pulses winner_flag/loser_flag when a tally hits TALLY_MAX.
// Latency : 1 cycle from init/control to count; no pipeline. Backpressure: none, every edge is consumed.
// Ports   : clk, rst (async active-high); init, init_value, control (00 +1, 01 +2, 10 -1, 11 -2);
//           count, winner_count, loser_count, winner_flag, loser_flag (all registered).
module multimode_counter_core #(
  parameter int WIDTH       = 4,
  parameter int TALLY_WIDTH = 4,
  parameter int TALLY_MAX   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init,
  input  logic [WIDTH-1:0]       init_value,
  input  logic [1:0]             control,
  output logic [WIDTH-1:0]       count,
  output logic [TALLY_WIDTH-1:0] winner_count,
  output logic [TALLY_WIDTH-1:0] loser_count,
  output logic                   winner_flag,
  output logic                   loser_flag
);

  localparam logic [TALLY_WIDTH-1:0] TALLY_END = TALLY_WIDTH'(TALLY_MAX);
  localparam logic [WIDTH-1:0]       ALL_ONES  = '1;
  localparam logic [WIDTH-1:0]       ZERO      = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       count_nxt;
  logic [TALLY_WIDTH-1:0] winner_nxt, loser_nxt;
  logic                   winner_flag_nxt, loser_flag_nxt;

  logic [WIDTH-1:0]       step_val;
  logic [WIDTH-1:0]       stepped;
  logic [TALLY_WIDTH-1:0] winner_inc, loser_inc;

  // Step arithmetic wraps silently modulo 2^WIDTH.
  assign step_val   = control[0] ? WIDTH'(2) : WIDTH'(1);
  assign stepped    = control[1] ? (count - step_val) : (count + step_val);
  assign winner_inc = winner_count + 1'b1;
  assign loser_inc  = loser_count + 1'b1;

  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    winner_nxt      = winner_count;
    loser_nxt       = loser_count;
    winner_flag_nxt = 1'b0;
    loser_flag_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (init) begin
          count_nxt = init_value;
          state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (init) begin
          // A freshly loaded value is never treated as an event.
          count_nxt = init_value;
        end else begin
          count_nxt = stepped;
          // WIDTH >= 2 means all-ones and zero are distinct, so at most one fires.
          if (stepped == ALL_ONES) begin
            winner_nxt = winner_inc;
            if (winner_inc == TALLY_END) begin
              winner_flag_nxt = 1'b1;
              state_nxt       = S_END;
            end
          end else if (stepped == ZERO) begin
            loser_nxt = loser_inc;
            if (loser_inc == TALLY_END) begin
              loser_flag_nxt = 1'b1;
              state_nxt      = S_END;
            end
          end
        end
      end

      S_END: begin
        // Single clean-up cycle; init is deliberately ignored here.
        count_nxt  = '0;
        winner_nxt = '0;
        loser_nxt  = '0;
        state_nxt  = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      winner_count <= '0;
      loser_count  <= '0;
      winner_flag  <= 1'b0;
      loser_flag   <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      winner_count <= winner_nxt;
      loser_count  <= loser_nxt;
      winner_flag  <= winner_flag_nxt;
      loser_flag   <= loser_flag_nxt;
    end
  end

endmodule

// File: tb/tb_multimode_counter_core.sv
// Purpose : Self-checking bench for multimode_counter_core: directed scenarios plus random stimulus
//           compared every cycle against a game-level reference model.
// Latency : model advances once per rising edge; outputs sampled 1 time unit after the edge.
module tb_multimode_counter_core;

  localparam int W  = 4;
  localparam int TW = 4;
  localparam int TM = 15;
  localparam int M  = 1 << W;

  logic          clk;
  logic          rst;
  logic          init;
  logic [W-1:0]  init_value;
  logic [1:0]    control;
  logic [W-1:0]  count;
  logic [TW-1:0] winner_count;
  logic [TW-1:0] loser_count;
  logic          winner_flag;
  logic          loser_flag;

  int n_tests = 0;
  int n_fail  = 0;

  multimode_counter_core #(
    .WIDTH       (W),
    .TALLY_WIDTH (TW),
    .TALLY_MAX   (TM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .init_value   (init_value),
    .control      (control),
    .count        (count),
    .winner_count (winner_count),
    .loser_count  (loser_count),
    .winner_flag  (winner_flag),
    .loser_flag   (loser_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (game rules in plain integers) ----------------
  int m_count, m_win, m_lose;
  bit m_wf, m_lf;
  bit m_playing;   // a game is in progress (loaded, not yet won/lost)
  bit m_over;      // a flag was just raised; next edge wipes the game

  function automatic void model_reset();
    m_count = 0; m_win = 0; m_lose = 0;
    m_wf = 0; m_lf = 0; m_playing = 0; m_over = 0;
  endfunction

  function automatic void model_edge(bit i, int v, int c);
    int delta;
    if (m_over) begin
      model_reset();
      return;
    end
    m_wf = 0;
    m_lf = 0;
    if (i) begin
      m_count   = v % M;
      m_playing = 1;
    end else if (m_playing) begin
      case (c)
        0: delta = 1;
        1: delta = 2;
        2: delta = -1;
        default: delta = -2;
      endcase
      m_count = (((m_count + delta) % M) + M) % M;
      if (m_count == M - 1) begin
        m_win++;
        if (m_win == TM) begin m_wf = 1; m_over = 1; m_playing = 0; end
      end
      if (m_count == 0) begin
        m_lose++;
        if (m_lose == TM) begin m_lf = 1; m_over = 1; m_playing = 0; end
      end
    end
  endfunction

  function automatic logic [W+2*TW+1:0] model_vec();
    logic [31:0] c, w, l;
    c = m_count; w = m_win; l = m_lose;
    return {c[W-1:0], w[TW-1:0], l[TW-1:0], m_wf, m_lf};
  endfunction

  function automatic logic [W+2*TW+1:0] dut_vec();
    return {count, winner_count, loser_count, winner_flag, loser_flag};
  endfunction

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic cycle(input bit i, input int v, input int c);
    logic [31:0] vv, cc;
    vv = v; cc = c;
    init       = i;
    init_value = vv[W-1:0];
    control    = cc[1:0];
    @(posedge clk);
    model_edge(i, v, c);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    init = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; init = 1'b0; init_value = '0; control = '0;
    model_reset();
    #2;
    n_tests++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), model_vec());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Idle with init low must hold zero regardless of control.
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, k);
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_idle_hold: got %h expected %h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_up_wrap();
    int exp_seq[5] = '{13, 14, 15, 0, 1};
    do_reset();
    cycle(1, 13, 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cycle(0, 0, 0);
      n_tests++;
      if (count !== W'(exp_seq[k]) || dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL up_wrap step %0d: got %h expected %h (count %0d)", k, dut_vec(), model_vec(), exp_seq[k]);
      end
    end
    n_tests++;
    if (winner_count !== TW'(1) || loser_count !== TW'(1)) begin
      n_fail++;
      $display("FAIL up_wrap_tallies: got win %0d lose %0d expected 1 1", winner_count, loser_count);
    end
  endtask

  task automatic test_mode_change();
    do_reset();
    cycle(1, 14, 1);
    cycle(0, 0, 1);
    n_tests++;
    if (count !== W'(0) || loser_count !== TW'(1) || winner_count !== TW'(0)) begin
      n_fail++;
      $display("FAIL mode_up2_wrap: got %h expected count 0 win 0 lose 1", dut_vec());
    end
    cycle(0, 0, 3);
    cycle(0, 0, 3);
    n_tests++;
    if (count !== W'(12) || loser_count !== TW'(1) || winner_count !== TW'(0) || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL mode_down2: got %h expected %h (count 12)", dut_vec(), model_vec());
    end
  endtask

  task automatic test_winner_game();
    int flag_cycles = 0;
    do_reset();
    for (int g = 1; g <= TM; g++) begin
      cycle(1, 14, 0);
      cycle(0, 0, 0);
      if (winner_flag === 1'b1) flag_cycles++;
      if (g < TM && (winner_flag !== 1'b0 || winner_count !== TW'(g))) begin
        n_tests++;
        n_fail++;
        $display("FAIL winner_progress step %0d: got %h expected win %0d no flag", g, dut_vec(), g);
      end
    end
    n_tests++;
    if (count !== W'(15) || winner_count !== TW'(TM) || winner_flag !== 1'b1 || loser_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL winner_final: got %h expected count f win %0d winner_flag 1", dut_vec(), TM);
    end
    cycle(0, 0, 0);
    n_tests++;
    if (dut_vec() !== '0 || flag_cycles != 1) begin
      n_fail++;
      $display("FAIL winner_cleanup: got %h flag_cycles %0d expected 0 and 1", dut_vec(), flag_cycles);
    end
    // Back in idle: nothing moves without init.
    cycle(0, 0, 0);
    n_tests++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL winner_idle: got %h expected 0", dut_vec());
    end
  endtask

  task automatic test_loser_game();
    bit saw_winner = 0;
    do_reset();
    for (int g = 1; g <= TM; g++) begin
      cycle(1, 1, 2);
      if (winner_flag === 1'b1) saw_winner = 1;
      cycle(0, 0, 2);
      if (winner_flag === 1'b1) saw_winner = 1;
    end
    n_tests++;
    if (count !== W'(0) || loser_count !== TW'(TM) || loser_flag !== 1'b1 || saw_winner) begin
      n_fail++;
      $display("FAIL loser_final: got %h saw_winner %0d expected lose %0d loser_flag 1 no winner", dut_vec(), saw_winner, TM);
    end
    cycle(0, 0, 2);
    n_tests++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL loser_cleanup: got %h expected 0", dut_vec());
    end
  endtask

  task automatic test_end_ignores_init();
    do_reset();
    for (int g = 1; g <= TM; g++) begin
      cycle(1, 14, 0);
      cycle(0, 0, 0);
    end
    cycle(1, 5, 0);   // lands on the END cycle
    n_tests++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL end_ignores_init: got %h expected 0", dut_vec());
    end
    cycle(1, 5, 0);
    cycle(0, 0, 0);
    n_tests++;
    if (count !== W'(6) || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL load_after_end: got %h expected %h (count 6)", dut_vec(), model_vec());
    end
  endtask

  task automatic test_async_reset_mid_run();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      cycle(1, 14, 0);
      cycle(0, 0, 0);
    end
    cycle(1, 8, 0);
    cycle(0, 0, 0);
    n_tests++;
    if (count !== W'(9) || winner_count !== TW'(3)) begin
      n_fail++;
      $display("FAIL async_setup: got count %0d win %0d expected 9 3", count, winner_count);
    end
    #3 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0 before next edge", dut_vec());
    end
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0);
      n_tests++;
      if (dut_vec() !== '0) begin
        n_fail++;
        $display("FAIL async_idle_hold: got %h expected 0", dut_vec());
      end
    end
  endtask

  task automatic test_random();
    int games_done = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 7) == 0), int'($urandom_range(0, M - 1)), int'($urandom_range(0, 3)));
      if (winner_flag === 1'b1 || loser_flag === 1'b1) games_done++;
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", n, dut_vec(), model_vec());
      end
    end
    n_tests++;
    if (games_done == 0) begin
      n_fail++;
      $display("FAIL random_games: got 0 finished games expected at least 1");
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_mode_change();
    test_winner_game();
    test_loser_game();
    test_end_ignores_init();
    test_async_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multimode_counter_core.md
Name: multimode_counter_core

Overview:
- Upstream stage of the game-state decision block.
- Runs a WIDTH-bit counter in one of four step modes.
- Tallies how many times the counter lands on all-ones (win event) and on zero (lose event).
- When a tally reaches TALLY_MAX, raises a one-cycle winner_flag or loser_flag, which the game-state block samples to set who/gameover. The core then clears itself and waits for a new init.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 2.
- TALLY_WIDTH, 4, width of the winner and loser tally counters.
- TALLY_MAX, 15, tally value that ends the game; must fit in TALLY_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init  in  1  load request; sampled at the clock edge.
- init_value  in  WIDTH  value loaded into count when init is accepted.
- control  in  2  step mode: 00 = up 1, 01 = up 2, 10 = down 1, 11 = down 2.
- count  out  WIDTH  current counter value (registered).
- winner_count  out  TALLY_WIDTH  number of win events this game.
- loser_count  out  TALLY_WIDTH  number of lose events this game.
- winner_flag  out  1  one-cycle pulse: winner tally reached TALLY_MAX.
- loser_flag  out  1  one-cycle pulse: loser tally reached TALLY_MAX.

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge):
  - count = 0, winner_count = 0, loser_count = 0, both flags = 0, state = IDLE.
  - Reset asserted mid-game discards all progress.
- All outputs are registered.
- State machine states: IDLE, RUN, END.
- IDLE:
  - count and tallies hold.
  - init = 1: count <= init_value, go to RUN.
  - init = 0: stay in IDLE.
- RUN, init = 1:
  - count <= init_value; tallies unchanged; no event check on the loaded value.
  - Stay in RUN.
- RUN, init = 0:
  - next = count ± step (step 1 or 2 per control), modulo 2^WIDTH. Wrap is silent: up 2 from 14 gives 0; down 1 from 0 gives 15 (WIDTH = 4).
  - count <= next.
  - If next = all-ones: winner_count increments.
  - If next = 0: loser_count increments.
  - Only one event is possible per cycle, since WIDTH >= 2.
  - If the incremented tally equals TALLY_MAX: the matching flag <= 1 in the same edge, state <= END. The tally shows TALLY_MAX while the flag is high.
- END (lasts exactly one cycle):
  - Flags <= 0, count <= 0, tallies <= 0, state <= IDLE.
  - init is ignored.
- Flag timing: each flag is high for exactly one clock period. The downstream block captures it on the following edge, and its gameover falls again on the edge after that.
- Flags are never both 1.
- Tallies never exceed TALLY_MAX, so no tally overflow is possible.
- A mode change on control takes effect on the next edge. There is no pipeline: the latency from control/init to count is 1 cycle.

Test Plan:
- Async reset mid-RUN: assert rst between clock edges while count = 9, winner_count = 3 -> all outputs 0 before the next edge; after release the block stays in IDLE until init is asserted.
- init = 1, init_value = 13, control = 00, then init = 0 -> count 13, 14, 15, 0, 1. winner_count becomes 1 at 15; loser_count becomes 1 at 0.
- init_value = 14, control = 01 -> next count 0, loser_count = 1. Then control = 11 -> count 14, 12, with no new events.
- Winner game: alternate one cycle init = 1 (init_value = 14) with one cycle init = 0 (control = 00), 15 times -> on the 15th step count = 15, winner_count = 15 and winner_flag = 1 for one cycle. Next edge: flag 0, count 0, tallies 0, state IDLE. Downstream sees who = 2, gameover = 1 for one cycle.
- Loser game: same pattern with init_value = 1, control = 10 -> loser_flag pulses after the 15th zero hit; winner_flag stays 0 throughout.
- init = 1 held during the END cycle -> ignored; count = 0 after END; the load happens on the following edge from IDLE.
